// File: rtl/cpu_types_pkg.sv
// Shared MIPS core types: machine word, RAM handshake state and arbiter grant state.
package cpu_types_pkg;

  localparam int WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter_watchdog.sv
// Per-access watchdog: counts granted cycles and flags the last cycle before abort.
module arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  assign expired = enable && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, data first.
// Optional macro MEM_ARB_FAIR_EN bounds instruction starvation to STARVE_LIMIT data grants.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W       = 32,
  parameter int TIMEOUT      = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  ramstate_t         ramstate,
  output logic              err_flag,
  output logic              timeout_flag,
  output arb_state_t        state
);

  logic d_req;
  logic granted;
  logic req_held;
  logic expired;
  logic pick_i;
  logic grant_i;
  logic i_done;
  logic d_done;

  assign d_req    = dREN | dWEN;
  assign granted  = (state != IDLE);
  assign req_held = ((state == DGRANT) & d_req) | ((state == IGRANT) & iREN);
  assign grant_i  = pick_i | (iREN & ~d_req);

`ifdef MEM_ARB_FAIR_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;

  assign pick_i = iREN && (starve_cnt == SW'(STARVE_LIMIT));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!iREN || grant_i) begin
        starve_cnt <= '0;
      end else if (d_req) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  // Strict data priority; the comparison is constant-false and keeps STARVE_LIMIT referenced.
  assign pick_i = iREN & (STARVE_LIMIT < 0);
`endif

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   (~granted),
    .enable  (granted),
    .expired (expired)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      err_flag     <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i)    state <= IGRANT;
          else if (d_req) state <= DGRANT;
        end
        default: begin
          if (!req_held || ramstate == ERROR || ramstate == ACCESS || expired)
            state <= IDLE;
        end
      endcase
      if (granted && req_held && ramstate == ERROR) err_flag <= 1'b1;
      if (granted && req_held && (ramstate == FREE || ramstate == BUSY) && expired)
        timeout_flag <= 1'b1;
    end
  end

  // RAM side is a pure function of the registered grant, so reset drops it at once.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      DGRANT: begin
        ramaddr = daddr;
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else begin
          ramREN = 1'b1;
        end
      end
      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
      end
      default: ;
    endcase
  end

  assign i_done = (state == IGRANT) && iREN && (ramstate == ACCESS);
  assign d_done = (state == DGRANT) && d_req && (ramstate == ACCESS);

  assign iwait = ~i_done;
  assign dwait = ~d_done;
  assign iload = i_done ? ramload : '0;
  assign dload = d_done ? ramload : '0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus random single-requester traffic.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int W  = 32;
  localparam int TO = 8;
  localparam int SL = 4;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          iREN, dREN, dWEN;
  logic [W-1:0]  iaddr, daddr, dstore, ramload;
  logic          iwait, dwait, ramREN, ramWEN, err_flag, timeout_flag;
  logic [W-1:0]  iload, dload, ramaddr, ramstore;
  ramstate_t     ramstate;
  arb_state_t    state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] ram_mem [0:15];
  logic [W-1:0] ref_mem [0:15];
  logic [W-1:0] exp_q [$];

  // clock/reset block
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL global_time_limit observed=running required=finished");
    $fatal(1, "time limit");
  end

  memory_arbiter #(.WORD_W(W), .TIMEOUT(TO), .STARVE_LIMIT(SL)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .err_flag(err_flag), .timeout_flag(timeout_flag), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    ramstate = FREE; ramload = '0;
  endtask

  // One transaction against a RAM that stalls `busy` cycles before ACCESS.
  task automatic do_access(input bit is_i, input bit is_w, input logic [3:0] idx,
                           input logic [31:0] data, input int busy);
    int cyc_n = 0;
    int bcnt = 0;
    bit done = 1'b0;
    bit other_ok = 1'b1;
    logic [31:0] got = '0;
    int lat = -1;
    @(negedge CLK);
    if (is_i) begin
      iREN = 1'b1; iaddr = {26'd0, idx, 2'b00};
    end else begin
      dREN = ~is_w; dWEN = is_w; daddr = {26'd0, idx, 2'b00}; dstore = data;
    end
    if (!is_w) exp_q.push_back(ref_mem[idx]);
    while (!done && cyc_n < 20) begin
      if (ramREN || ramWEN) begin
        if (bcnt < busy) begin ramstate = BUSY; bcnt++; end
        else ramstate = ACCESS;
        ramload = ramREN ? ram_mem[ramaddr[5:2]] : '0;
      end else begin
        ramstate = FREE; ramload = '0;
      end
      #1;
      if (is_i ? !iwait : !dwait) begin
        done = 1'b1; lat = cyc_n; got = is_i ? iload : dload;
        if (ramWEN) ram_mem[ramaddr[5:2]] = ramstore;
      end
      if (is_i ? !dwait : !iwait) other_ok = 1'b0;
      cyc_n++;
      if (!done) @(negedge CLK);
    end
    @(negedge CLK);
    idle_inputs();
    chk("rnd_done", 32'(done), 32'd1);
    chk("rnd_latency", 32'(lat), 32'(busy + 1));
    chk("rnd_other_wait", 32'(other_ok), 32'd1);
    if (is_w) ref_mem[idx] = data;
    else if (exp_q.size() > 0) chk("rnd_load", got, exp_q.pop_front());
  endtask

  initial begin
    int d_run;
    int grants;
    int cyc_n;
    bit exp_i;
    bit fair;
`ifdef MEM_ARB_FAIR_EN
    fair = 1'b1;
`else
    fair = 1'b0;
`endif
    for (int k = 0; k < 16; k++) begin ram_mem[k] = '0; ref_mem[k] = '0; end
    nRST = 1'b0; iaddr = '0; daddr = '0; dstore = '0;
    idle_inputs();

    // Reset state
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_state", 32'(state), 32'(IDLE));
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_ramen", {30'd0, ramREN, ramWEN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_loads", iload | dload, 32'd0);
    chk("rst_flags", {30'd0, err_flag, timeout_flag}, 32'd0);
    @(negedge CLK); nRST = 1'b1;

    // Instruction fetch, ACCESS on first granted cycle
    @(negedge CLK); iREN = 1'b1; iaddr = 32'h40; #1;
    chk("if_c0_state", 32'(state), 32'(IDLE));
    chk("if_c0_iwait", 32'(iwait), 32'd1);
    @(negedge CLK); ramstate = ACCESS; ramload = 32'h2408000A; #1;
    chk("if_c1_state", 32'(state), 32'(IGRANT));
    chk("if_c1_ram", {ramREN, ramWEN, 30'd0} | ramaddr, 32'h80000040);
    chk("if_c1_iwait", 32'(iwait), 32'd0);
    chk("if_c1_iload", iload, 32'h2408000A);
    chk("if_c1_dwait", 32'(dwait), 32'd1);
    @(negedge CLK); idle_inputs(); #1;
    chk("if_c2_state", 32'(state), 32'(IDLE));
    chk("if_c2_iwait", 32'(iwait), 32'd1);
    chk("if_c2_iload", iload, 32'd0);

    // Collision: data write first, then the fetch
    @(negedge CLK);
    iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF; #1;
    chk("col_c0_state", 32'(state), 32'(IDLE));
    @(negedge CLK); ramstate = ACCESS; #1;
    chk("col_c1_state", 32'(state), 32'(DGRANT));
    chk("col_c1_en", {30'd0, ramREN, ramWEN}, 32'd1);
    chk("col_c1_addr", ramaddr, 32'h100);
    chk("col_c1_store", ramstore, 32'hDEADBEEF);
    chk("col_c1_dwait", 32'(dwait), 32'd0);
    chk("col_c1_iwait", 32'(iwait), 32'd1);
    @(negedge CLK); dWEN = 1'b0; ramstate = FREE; #1;
    chk("col_c2_state", 32'(state), 32'(IDLE));
    chk("col_c2_iwait", 32'(iwait), 32'd1);
    @(negedge CLK); ramstate = BUSY; #1;
    chk("col_c3_state", 32'(state), 32'(IGRANT));
    chk("col_c3_addr", ramaddr, 32'h44);
    chk("col_c3_iwait", 32'(iwait), 32'd1);
    @(negedge CLK); ramstate = ACCESS; ramload = 32'h8C090004; #1;
    chk("col_c4_iwait", 32'(iwait), 32'd0);
    chk("col_c4_iload", iload, 32'h8C090004);
    @(negedge CLK); idle_inputs();

    // Data read with three BUSY cycles
    @(negedge CLK); dREN = 1'b1; daddr = 32'h200; #1;
    for (int g = 1; g <= 3; g++) begin
      @(negedge CLK); ramstate = BUSY; #1;
      chk("busy_dwait", 32'(dwait), 32'd1);
      chk("busy_ren", 32'(ramREN), 32'd1);
    end
    @(negedge CLK); ramstate = ACCESS; ramload = 32'h00C0FFEE; #1;
    chk("busy_done_dwait", 32'(dwait), 32'd0);
    chk("busy_done_dload", dload, 32'h00C0FFEE);
    @(negedge CLK); idle_inputs(); #1;
    chk("busy_no_timeout", 32'(timeout_flag), 32'd0);

    // Withdrawn request: no wait pulse even if RAM answers
    @(negedge CLK); dREN = 1'b1; daddr = 32'h208;
    @(negedge CLK); ramstate = BUSY; #1;
    chk("wd_state", 32'(state), 32'(DGRANT));
    @(negedge CLK); dREN = 1'b0; ramstate = ACCESS; #1;
    chk("wd_dwait", 32'(dwait), 32'd1);
    @(negedge CLK); idle_inputs(); #1;
    chk("wd_idle", 32'(state), 32'(IDLE));

    // RAM error: flag, no pulse, re-arbitration
    @(negedge CLK); iREN = 1'b1; iaddr = 32'h48;
    @(negedge CLK); ramstate = ERROR; #1;
    chk("err_state", 32'(state), 32'(IGRANT));
    chk("err_iwait", 32'(iwait), 32'd1);
    @(negedge CLK); ramstate = FREE; #1;
    chk("err_idle", 32'(state), 32'(IDLE));
    chk("err_flag", 32'(err_flag), 32'd1);
    @(negedge CLK); ramstate = ACCESS; ramload = 32'h55; #1;
    chk("err_regrant", 32'(state), 32'(IGRANT));
    chk("err_retry_iwait", 32'(iwait), 32'd0);
    @(negedge CLK); idle_inputs();

    // Watchdog: stuck BUSY for TO granted cycles
    @(negedge CLK); dREN = 1'b1; daddr = 32'h204;
    for (int g = 1; g <= TO; g++) begin
      @(negedge CLK); ramstate = BUSY; #1;
      chk($sformatf("to_g%0d_state", g), 32'(state), 32'(DGRANT));
      chk($sformatf("to_g%0d_flag", g), 32'(timeout_flag), 32'd0);
      chk($sformatf("to_g%0d_dwait", g), 32'(dwait), 32'd1);
    end
    @(negedge CLK); idle_inputs(); #1;
    chk("to_idle", 32'(state), 32'(IDLE));
    chk("to_flag", 32'(timeout_flag), 32'd1);
    chk("to_err_sticky", 32'(err_flag), 32'd1);

    // Random single-requester traffic against the memory model
    for (int t = 0; t < 24; t++) begin
      bit ii, ww;
      ii = 1'($urandom_range(0, 1));
      ww = ii ? 1'b0 : 1'($urandom_range(0, 1));
      do_access(ii, ww, 4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3));
    end

    // Fairness / strict priority under continuous contention
    @(negedge CLK); idle_inputs();
    @(negedge CLK);
    dREN = 1'b1; daddr = 32'h300; iREN = 1'b1; iaddr = 32'h80;
    d_run = 0; grants = 0; cyc_n = 0;
    while (grants < 12 && cyc_n < 60) begin
      ramstate = (ramREN || ramWEN) ? ACCESS : FREE;
      #1;
      if (state == DGRANT || state == IGRANT) begin
        exp_i = fair && (d_run == SL);
        chk($sformatf("grant_%0d_is_i", grants), 32'(state == IGRANT), 32'(exp_i));
        if (exp_i) d_run = 0; else d_run++;
        grants++;
      end
      cyc_n++;
      @(negedge CLK);
    end
    chk("grant_count", 32'(grants), 32'd12);
    idle_inputs();

    // Reset during a data write grant
    @(negedge CLK); dWEN = 1'b1; daddr = 32'h104; dstore = 32'h12345678;
    @(negedge CLK); ramstate = BUSY; #1;
    chk("rmid_wen_before", 32'(ramWEN), 32'd1);
    #2 nRST = 1'b0; #1;
    chk("rmid_en", {30'd0, ramREN, ramWEN}, 32'd0);
    chk("rmid_state", 32'(state), 32'(IDLE));
    chk("rmid_waits", {30'd0, iwait, dwait}, 32'd3);
    chk("rmid_flags", {30'd0, err_flag, timeout_flag}, 32'd0);
    @(negedge CLK); idle_inputs(); nRST = 1'b1;
    @(negedge CLK);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single-port unified RAM between the instruction-fetch requester and the data-access requester of the MIPS core.
- Sits between the request_unit/datapath memory signals and the RAM model.
- Registered grant FSM with data-over-instruction priority.
- Per-access watchdog, plus sticky error and timeout flags for the bench and halt logic.

Parameters:
- WORD_W, 32, data/address word width.
- TIMEOUT, 64, max cycles a granted access may wait for ramstate==ACCESS before abort.
- STARVE_LIMIT, 4, consecutive data grants tolerated while iREN pending (used only with MEM_ARB_FAIR_EN).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction read request.
- iaddr  in  WORD_W  instruction address.
- iwait  out  1  instruction stall; 0 for exactly the completing cycle.
- iload  out  WORD_W  instruction read data.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  WORD_W  data address.
- dstore  in  WORD_W  write data.
- dwait  out  1  data stall; 0 for exactly the completing cycle.
- dload  out  WORD_W  data read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- err_flag  out  1  sticky: ramstate==ERROR seen during a grant.
- timeout_flag  out  1  sticky: watchdog expired.

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is asynchronous, active-low.
- Reset values: state=IDLE, ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0, watchdog=0, starve count=0, both flags=0. Reset mid-access drops RAM enables immediately; the access is lost.
- States: IDLE, DGRANT, IGRANT.
- IDLE: no RAM enables asserted.
  - (dREN|dWEN) -> DGRANT.
  - else iREN -> IGRANT.
  - else stay in IDLE.
- DGRANT: RAM outputs are a combinational pass-through of the d side.
  - ramaddr=daddr.
  - dWEN=1 -> ramWEN=1, ramstore=dstore, ramREN=0 (write wins if both dREN and dWEN are set).
  - else ramREN=1.
- IGRANT: ramREN=1, ramaddr=iaddr, ramWEN=0.
- Completion: the granted side sees wait=0 in the cycle ramstate==ACCESS. load=ramload in that cycle (combinational); load is 0 otherwise. Next state is IDLE.
- Latency: minimum 2 cycles from request to completion (1 arbitration cycle + 1 RAM cycle); RAM BUSY cycles add directly. Back-to-back accesses always pass through one IDLE cycle.
- Ungranted side: wait stays 1 throughout.
- Abort on withdrawn request: granted requester drops its request (DGRANT with dREN=dWEN=0, or IGRANT with iREN=0) -> IDLE next cycle; no wait=0 pulse.
- Abort on RAM error: ramstate==ERROR while granted -> err_flag<=1, wait stays 1, IDLE next cycle; the requester is re-arbitrated if still requesting.
- Watchdog: counts cycles in a grant state, cleared on entering a grant state. Reaching TIMEOUT-1 without ACCESS -> timeout_flag<=1, IDLE next cycle.
- Flags clear only on reset.
- Simultaneous iREN and dREN/dWEN in IDLE: data granted (base behaviour).

Optional Feature:
- Macro: MEM_ARB_FAIR_EN.
- When defined: a starve counter increments on each DGRANT entry taken while iREN=1; it clears on IGRANT entry, or when iREN=0 in IDLE. When the counter equals STARVE_LIMIT and iREN=1, IDLE grants IGRANT even if data is requesting.
- When undefined: strict data priority; no counter is synthesized; STARVE_LIMIT is ignored.

Decomposition:
- cpu_types_pkg gains:
  - word_t, if not already present.
  - ramstate_t enum {FREE, BUSY, ACCESS, ERROR}, 2 bits.
  - arb_state_t enum {IDLE, DGRANT, IGRANT}.
- One sub-module: arb_watchdog.
  - Ports: CLK, nRST, clear, enable, expired.
  - Parameterized by TIMEOUT; counter width $clog2(TIMEOUT).

Test Plan:
- Reset asserted mid-DGRANT with ramWEN=1 -> ramWEN/ramREN drop immediately; iwait=dwait=1; state IDLE; flags 0.
- iREN=1, iaddr=0x40, RAM returns ACCESS on the 1st granted cycle with ramload=0x2408000A -> IGRANT on cycle 1, iwait=0 and iload=0x2408000A on cycle 1 only, IDLE on cycle 2.
- Collision: iREN=1 and dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF first; dwait pulses 0; then IGRANT follows; iwait stays 1 until its own ACCESS.
- RAM holds BUSY for 3 cycles then ACCESS on a dREN at 0x200 -> dwait=1 for 3 granted cycles, 0 on the 4th; watchdog does not fire.
- RAM stuck BUSY with TIMEOUT=8 -> timeout_flag=1 after 8 granted cycles, IDLE next cycle. Separately, ramstate=ERROR during a grant -> err_flag=1 and no wait pulse.
- With MEM_ARB_FAIR_EN, STARVE_LIMIT=4: dREN and iREN held high continuously -> grant sequence D,D,D,D,I,D,… Without the macro -> I is never granted.
